// File: rtl/lpr_boundary_detect_pkg.sv
// lpr_boundary_detect_pkg
//   Shared definitions for the plate-location boundary detector.
//   - CW / CW_MAX : width and all-ones value of every pixel/line count.
//   - state_t     : frame FSM states.
//   - sat_add     : add with an upper clamp, computed one bit wider so it never wraps.
//   - sat_sub     : subtract that floors at zero, computed one bit wider.
//   - LPR_EDGE_TO : true in the cycle a signal arrives at level `lvl`,
//                   given its registered copy `q` and current value `d`.

`ifndef LPR_EDGE_TO
`define LPR_EDGE_TO(q, d, lvl) (((d) == (lvl)) && ((q) != (lvl)))
`endif

package lpr_boundary_detect_pkg;

  localparam int            CW     = 12;
  localparam logic [CW-1:0] CW_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    COMMIT
  } state_t;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic [CW-1:0] lim);
    logic [CW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[CW-1:0];
  endfunction

  // The extra top bit is the borrow: set exactly when b > a.
  function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    logic [CW:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[CW] ? '0 : diff[CW-1:0];
  endfunction

endpackage

// File: rtl/lpr_boundary_detect_if.sv
// lpr_boundary_detect_if
//   Video-in / box-out bundle of the boundary detector.
//   Inputs to the detector : i_bin, i_hsync, i_vsync, i_de, hcount, vcount.
//   Outputs of the detector: hcount_l, hcount_r, vcount_l, vcount_r,
//                            o_found, o_update, o_hsync (registered i_hsync).
//   master = the video source / box consumer side, slave = the detector.

interface lpr_boundary_detect_if;
  import lpr_boundary_detect_pkg::*;

  logic          i_bin;
  logic          i_hsync;
  logic          i_vsync;
  logic          i_de;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic [CW-1:0] hcount_l;
  logic [CW-1:0] hcount_r;
  logic [CW-1:0] vcount_l;
  logic [CW-1:0] vcount_r;
  logic          o_found;
  logic          o_update;
  logic          o_hsync;

  modport master (
    output i_bin, i_hsync, i_vsync, i_de, hcount, vcount,
    input  hcount_l, hcount_r, vcount_l, vcount_r, o_found, o_update, o_hsync
  );

  modport slave (
    input  i_bin, i_hsync, i_vsync, i_de, hcount, vcount,
    output hcount_l, hcount_r, vcount_l, vcount_r, o_found, o_update, o_hsync
  );

endinterface

// File: rtl/lpr_boundary_detect_line_profile.sv
// lpr_line_profile
//   Per-line foreground profile: counts foreground pixels of the current line
//   and remembers the first/last foreground column and the line number.
//   Ports:
//     pixelclk, reset_n   clock, asynchronous active-low reset
//     de, bin             data enable and foreground flag of the current pixel
//     hcount, vcount      column / line of the current pixel
//     en                  accumulate only while high; profile held clear otherwise
//     drop                discard the line in progress (frame boundary)
//     line_end            high in the cycle after the last active pixel of a line
//     line_q              the finished line has at least ROW_MIN foreground pixels
//     lmin, lmax, line_v  first / last foreground column and line number

module lpr_line_profile
  import lpr_boundary_detect_pkg::*;
#(
  parameter int ROW_MIN = 8
) (
  input  logic          pixelclk,
  input  logic          reset_n,
  input  logic          de,
  input  logic          bin,
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  input  logic          en,
  input  logic          drop,
  output logic          line_end,
  output logic          line_q,
  output logic [CW-1:0] lmin,
  output logic [CW-1:0] lmax,
  output logic [CW-1:0] line_v
);

  logic          de_q;
  logic [CW-1:0] cnt;

  assign line_end = `LPR_EDGE_TO(de_q, de, 1'b0);
  assign line_q   = (cnt >= CW'(ROW_MIN));

  // The profile is cleared in the same edge that hands it to the frame
  // accumulators, so line_end/line_q/lmin/lmax are valid together.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      de_q   <= 1'b0;
      cnt    <= '0;
      lmin   <= '0;
      lmax   <= '0;
      line_v <= '0;
    end else begin
      de_q <= de;
      if (de) line_v <= vcount;
      if (line_end || drop || !en) begin
        cnt  <= '0;
        lmin <= '0;
        lmax <= '0;
      end else if (de && bin) begin
        if (cnt == '0) lmin <= hcount;
        lmax <= hcount;
        cnt  <= sat_add(cnt, CW'(1), CW_MAX);
      end
    end
  end

endmodule

// File: rtl/lpr_boundary_detect.sv
// lpr_boundary_detect
//   Bounding box of foreground pixels in a binarized video stream. A box is
//   accumulated over one frame, expanded by MARGIN on every side (clamped to
//   the active area) and presented from the next frame on.
//   Ports:
//     pixelclk  pixel clock
//     reset_n   asynchronous active-low reset
//     vif       lpr_boundary_detect_if.slave: video in, box/found/update out
//   Box outputs change two cycles after the vsync active edge on i_vsync and
//   stay constant between o_update pulses.

module lpr_boundary_detect
  import lpr_boundary_detect_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int ROW_MIN  = 8,
  parameter int MIN_ROWS = 4,
  parameter int MARGIN   = 2,
  parameter bit VS_POL   = 1'b1
) (
  input logic                  pixelclk,
  input logic                  reset_n,
  lpr_boundary_detect_if.slave vif
);

  state_t        state;
  logic          vs_q;
  logic          hs_q;
  logic          vs_edge;
  logic          line_end;
  logic          line_q;
  logic [CW-1:0] lmin, lmax, line_v;
  logic [CW-1:0] hmin, hmax, vmin, vmax, rows;
  logic [CW-1:0] hcount_l, hcount_r, vcount_l, vcount_r;
  logic          o_found, o_update;

  assign vs_edge = `LPR_EDGE_TO(vs_q, vif.i_vsync, VS_POL);

  // A vsync edge while i_de is still high drops the open line.
  lpr_line_profile #(
    .ROW_MIN (ROW_MIN)
  ) u_line_profile (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .de       (vif.i_de),
    .bin      (vif.i_bin),
    .hcount   (vif.hcount),
    .vcount   (vif.vcount),
    .en       (state == ACCUM),
    .drop     (vs_edge),
    .line_end (line_end),
    .line_q   (line_q),
    .lmin     (lmin),
    .lmax     (lmax),
    .line_v   (line_v)
  );

  // Frame FSM, accumulators and output registers. vs_q resets to the active
  // level so a vsync pulse already in progress at reset release is not taken
  // as an edge. A line ending in the same cycle as the vsync edge is folded
  // in on that edge, before COMMIT reads the accumulators.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT_FRAME;
      vs_q     <= VS_POL;
      hs_q     <= 1'b0;
      hmin     <= '0;
      hmax     <= '0;
      vmin     <= '0;
      vmax     <= '0;
      rows     <= '0;
      hcount_l <= '0;
      hcount_r <= '0;
      vcount_l <= '0;
      vcount_r <= '0;
      o_found  <= 1'b0;
      o_update <= 1'b0;
    end else begin
      vs_q     <= vif.i_vsync;
      hs_q     <= vif.i_hsync;
      o_update <= 1'b0;

      if (state != ACCUM) begin
        hmin <= CW_MAX;
        hmax <= '0;
        vmin <= CW_MAX;
        vmax <= '0;
        rows <= '0;
      end else if (line_end && line_q) begin
        if (lmin < hmin)   hmin <= lmin;
        if (lmax > hmax)   hmax <= lmax;
        if (line_v < vmin) vmin <= line_v;
        vmax <= line_v;
        rows <= sat_add(rows, CW'(1), CW_MAX);
      end

      unique case (state)
        WAIT_FRAME: if (vs_edge) state <= ACCUM;
        ACCUM:      if (vs_edge) state <= COMMIT;
        COMMIT: begin
          if (rows >= CW'(MIN_ROWS)) begin
            hcount_l <= sat_sub(hmin, CW'(MARGIN));
            hcount_r <= sat_add(hmax, CW'(MARGIN), CW'(H_ACTIVE - 1));
            vcount_l <= sat_sub(vmin, CW'(MARGIN));
            vcount_r <= sat_add(vmax, CW'(MARGIN), CW'(V_ACTIVE - 1));
            o_found  <= 1'b1;
          end else begin
            o_found  <= 1'b0;
          end
          o_update <= 1'b1;
          state    <= ACCUM;
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

  assign vif.hcount_l = hcount_l;
  assign vif.hcount_r = hcount_r;
  assign vif.vcount_l = vcount_l;
  assign vif.vcount_r = vcount_r;
  assign vif.o_found  = o_found;
  assign vif.o_update = o_update;
  assign vif.o_hsync  = hs_q;

endmodule

// File: tb/tb_lpr_boundary_detect.sv
// tb_lpr_boundary_detect
//   Directed bench for lpr_boundary_detect. Two detectors see the same video:
//   dut_a uses the default build (active-high vsync, ROW_MIN=8); dut_b is an
//   active-low vsync build fed the inverted vsync, with ROW_MIN=4 so the
//   narrow corner boxes can qualify. Each frame's expected box per detector
//   is pushed to a queue when the frame is driven and popped when o_update
//   is due, two cycles after the vsync edge.

module tb_lpr_boundary_detect;
  import lpr_boundary_detect_pkg::*;

  localparam int H_ACTIVE  = 1920;
  localparam int V_ACTIVE  = 1080;
  localparam int MIN_ROWS  = 4;
  localparam int MARGIN    = 2;
  localparam int ROW_MIN_A = 8;
  localparam int ROW_MIN_B = 4;

  typedef struct packed {
    logic          found;
    logic [CW-1:0] l;
    logic [CW-1:0] r;
    logic [CW-1:0] t;
    logic [CW-1:0] b;
  } box_t;

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;

  always #5 pixelclk = ~pixelclk;

  lpr_boundary_detect_if bus_a ();
  lpr_boundary_detect_if bus_b ();

  assign bus_b.i_bin   = bus_a.i_bin;
  assign bus_b.i_hsync = bus_a.i_hsync;
  assign bus_b.i_vsync = ~bus_a.i_vsync;
  assign bus_b.i_de    = bus_a.i_de;
  assign bus_b.hcount  = bus_a.hcount;
  assign bus_b.vcount  = bus_a.vcount;

  lpr_boundary_detect #(
    .H_ACTIVE (H_ACTIVE), .V_ACTIVE (V_ACTIVE), .ROW_MIN (ROW_MIN_A),
    .MIN_ROWS (MIN_ROWS), .MARGIN (MARGIN), .VS_POL (1'b1)
  ) dut_a (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .vif      (bus_a.slave)
  );

  lpr_boundary_detect #(
    .H_ACTIVE (H_ACTIVE), .V_ACTIVE (V_ACTIVE), .ROW_MIN (ROW_MIN_B),
    .MIN_ROWS (MIN_ROWS), .MARGIN (MARGIN), .VS_POL (1'b0)
  ) dut_b (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .vif      (bus_b.slave)
  );

  box_t q_a[$];
  box_t q_b[$];
  box_t prev_a = '0;
  box_t prev_b = '0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   pushed       = 0;
  int   upd_a        = 0;
  int   upd_b        = 0;

  always @(negedge pixelclk) begin
    if (bus_a.o_update === 1'b1) upd_a++;
    if (bus_b.o_update === 1'b1) upd_b++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_box(input string who, input box_t e, input logic found,
                           input logic upd, input logic [CW-1:0] l, input logic [CW-1:0] r,
                           input logic [CW-1:0] t, input logic [CW-1:0] b);
    check_output({who, "_update"}, 32'(upd), 32'd1);
    check_output({who, "_found"}, 32'(found), 32'(e.found));
    check_output({who, "_hcount_l"}, 32'(l), 32'(e.l));
    check_output({who, "_hcount_r"}, 32'(r), 32'(e.r));
    check_output({who, "_vcount_l"}, 32'(t), 32'(e.t));
    check_output({who, "_vcount_r"}, 32'(b), 32'(e.b));
  endtask

  // Reference box for a frame of identical lines yt..yb, each carrying nfg
  // foreground pixels from column xl to column xr.
  function automatic box_t model_box(input box_t prev, input int xl, input int xr,
                                     input int yt, input int yb, input int nfg,
                                     input bit has_de, input int row_min);
    box_t e;
    int   rows;
    e    = prev;
    rows = (has_de && nfg >= row_min) ? (yb - yt + 1) : 0;
    if (rows >= MIN_ROWS) begin
      e.found = 1'b1;
      e.l = CW'((xl >= MARGIN) ? xl - MARGIN : 0);
      e.r = CW'((xr + MARGIN > H_ACTIVE - 1) ? H_ACTIVE - 1 : xr + MARGIN);
      e.t = CW'((yt >= MARGIN) ? yt - MARGIN : 0);
      e.b = CW'((yb + MARGIN > V_ACTIVE - 1) ? V_ACTIVE - 1 : yb + MARGIN);
    end else begin
      e.found = 1'b0;
    end
    return e;
  endfunction

  task automatic drive_pixel(input int h, input int v, input bit bin);
    @(negedge pixelclk);
    bus_a.i_de    = 1'b1;
    bus_a.i_hsync = 1'b0;
    bus_a.i_bin   = bin;
    bus_a.hcount  = CW'(h);
    bus_a.vcount  = CW'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pixelclk);
      bus_a.i_de    = 1'b0;
      bus_a.i_bin   = 1'b0;
      bus_a.i_hsync = 1'b1;
    end
  endtask

  // Background pixel, nfg-1 foreground pixels from xl, foreground at xr,
  // background pixel; close=0 leaves i_de high for the caller to drop.
  task automatic drive_line(input int v, input int xl, input int xr, input int nfg, input bit close);
    drive_pixel((xl > 0) ? xl - 1 : xl, v, 1'b0);
    for (int i = 0; i < nfg - 1; i++) drive_pixel(xl + i, v, 1'b1);
    drive_pixel(xr, v, 1'b1);
    drive_pixel((xr < H_ACTIVE - 1) ? xr + 1 : xr, v, 1'b0);
    if (close) idle(3);
  endtask

  // Vsync active edge, then the o_update pulse must be exactly on the 2nd cycle.
  task automatic frame_end(input bit expect_update);
    box_t ea, eb;
    @(negedge pixelclk);
    bus_a.i_vsync = 1'b1;
    bus_a.i_de    = 1'b0;
    bus_a.i_bin   = 1'b0;
    @(negedge pixelclk);
    check_output("a_update_early", 32'(bus_a.o_update), 32'd0);
    check_output("b_update_early", 32'(bus_b.o_update), 32'd0);
    @(negedge pixelclk);
    if (expect_update) begin
      check_output("sb_a_pending", 32'(q_a.size() > 0), 32'd1);
      check_output("sb_b_pending", 32'(q_b.size() > 0), 32'd1);
      ea = (q_a.size() > 0) ? q_a.pop_front() : '0;
      eb = (q_b.size() > 0) ? q_b.pop_front() : '0;
      check_box("a", ea, bus_a.o_found, bus_a.o_update, bus_a.hcount_l,
                bus_a.hcount_r, bus_a.vcount_l, bus_a.vcount_r);
      check_box("b", eb, bus_b.o_found, bus_b.o_update, bus_b.hcount_l,
                bus_b.hcount_r, bus_b.vcount_l, bus_b.vcount_r);
    end else begin
      check_output("a_no_update", 32'(bus_a.o_update), 32'd0);
      check_output("b_no_update", 32'(bus_b.o_update), 32'd0);
    end
    @(negedge pixelclk);
    check_output("a_update_late", 32'(bus_a.o_update), 32'd0);
    check_output("b_update_late", 32'(bus_b.o_update), 32'd0);
    bus_a.i_vsync = 1'b0;
  endtask

  // One full frame; tight=1 lets the last line's i_de fall with the vsync edge.
  task automatic apply_stimulus(input int xl, input int xr, input int yt, input int yb,
                                input int nfg, input bit has_de, input bit tight);
    prev_a = model_box(prev_a, xl, xr, yt, yb, nfg, has_de, ROW_MIN_A);
    prev_b = model_box(prev_b, xl, xr, yt, yb, nfg, has_de, ROW_MIN_B);
    q_a.push_back(prev_a);
    q_b.push_back(prev_b);
    pushed++;
    if (has_de) begin
      for (int v = yt; v <= yb; v++) drive_line(v, xl, xr, nfg, !(tight && v == yb));
    end else begin
      idle(20);
    end
    frame_end(1'b1);
  endtask

  task automatic check_reset_outputs(input string who, input logic found, input logic upd,
                                     input logic [CW-1:0] l, input logic [CW-1:0] r,
                                     input logic [CW-1:0] t, input logic [CW-1:0] b);
    check_output({who, "_rst_found"}, 32'(found), 32'd0);
    check_output({who, "_rst_update"}, 32'(upd), 32'd0);
    check_output({who, "_rst_box"}, {8'd0, l | r | t | b}, 32'd0);
  endtask

  initial begin
    bus_a.i_bin   = 1'b0;
    bus_a.i_hsync = 1'b1;
    bus_a.i_vsync = 1'b0;
    bus_a.i_de    = 1'b0;
    bus_a.hcount  = '0;
    bus_a.vcount  = '0;
    reset_n       = 1'b0;

    repeat (3) @(negedge pixelclk);
    check_reset_outputs("a", bus_a.o_found, bus_a.o_update, bus_a.hcount_l,
                        bus_a.hcount_r, bus_a.vcount_l, bus_a.vcount_r);
    check_reset_outputs("b", bus_b.o_found, bus_b.o_update, bus_b.hcount_l,
                        bus_b.hcount_r, bus_b.vcount_l, bus_b.vcount_r);
    reset_n = 1'b1;
    idle(5);

    // First edge after reset only starts accumulation.
    frame_end(1'b0);

    // Rectangle h 100..299, v 50..149: both builds give 98/301/48/151.
    apply_stimulus(100, 299, 50, 149, 8, 1'b1, 1'b0);
    // Seven foreground pixels per line: dut_a holds, dut_b (ROW_MIN=4) finds.
    apply_stimulus(500, 700, 200, 260, 7, 1'b1, 1'b0);
    // Corner boxes: clamp at 0 and at 1919/1079.
    apply_stimulus(0, 5, 0, 3, 6, 1'b1, 1'b0);
    apply_stimulus(1915, 1919, 1076, 1079, 5, 1'b1, 1'b0);
    apply_stimulus(1, 300, 1, 20, 8, 1'b1, 1'b0);
    apply_stimulus(1900, 1918, 1070, 1078, 8, 1'b1, 1'b0);
    // Three qualifying rows are too few, four are enough.
    apply_stimulus(10, 100, 10, 12, 8, 1'b1, 1'b0);
    apply_stimulus(10, 100, 10, 13, 8, 1'b1, 1'b0);
    // Last line's i_de falls with the vsync edge and still counts.
    apply_stimulus(200, 400, 300, 309, 8, 1'b1, 1'b1);
    // No active pixels at all.
    apply_stimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    for (int v = 400; v <= 404; v++) drive_line(v, 700, 900, 8, 1'b1);
    @(negedge pixelclk);
    reset_n = 1'b0;
    @(negedge pixelclk);
    check_reset_outputs("a_mid", bus_a.o_found, bus_a.o_update, bus_a.hcount_l,
                        bus_a.hcount_r, bus_a.vcount_l, bus_a.vcount_r);
    check_reset_outputs("b_mid", bus_b.o_found, bus_b.o_update, bus_b.hcount_l,
                        bus_b.hcount_r, bus_b.vcount_l, bus_b.vcount_r);
    reset_n = 1'b1;
    prev_a  = '0;
    prev_b  = '0;
    for (int v = 405; v <= 420; v++) drive_line(v, 700, 900, 8, 1'b1);
    frame_end(1'b0);
    check_output("a_partial_not_found", 32'(bus_a.o_found), 32'd0);
    check_output("a_partial_box", {8'd0, bus_a.hcount_r}, 32'd0);
    apply_stimulus(100, 299, 50, 149, 8, 1'b1, 1'b0);

    idle(5);
    check_output("a_update_count", 32'(upd_a), 32'(pushed));
    check_output("b_update_count", 32'(upd_b), 32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
